// File: rtl/phy_pkg.sv
// Shared definitions for the SerDes link block.
// Holds default flit/lane/FIFO sizes, the TX state encoding and a small
// helper used for elaboration-time parameter checks.
package phy_pkg;

    localparam int FLIT_W_DEF   = 32;
    localparam int LANE_W_DEF   = 8;
    localparam int RX_DEPTH_DEF = 4;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/phy_rx_fifo.sv
// Receive FIFO for assembled flits.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push_i, wdata_i   write request and data; ignored when full unless a
//                     pop happens in the same cycle
//   pop_i             remove head; ignored when empty
//   rdata_o           current head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries (0..DEPTH)
module phy_rx_fifo
    import phy_pkg::*;
#(
    parameter int WIDTH = FLIT_W_DEF,
    parameter int DEPTH = RX_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves at the same edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/phy_serdes_link.sv
// Flit-to-lane serialiser / lane-to-flit deserialiser for a router port.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   enable_send/enable_receive  gate new TX frames / RX space advertisement
//   input_*                     router TX flit handshake (1-entry holding reg)
//   output_*                    router RX flit handshake (FIFO head)
//   serial_data_out, write_req_send   outgoing lane beats and frame strobe
//   write_ready_ack             peer can take one whole frame
//   serial_data_in, read_req_received incoming lane beats and frame strobe
//   read_ready                  this side can take one whole frame
//   rx_frame_err                one-cycle pulse on truncated or dropped frame
module phy_serdes_link
    import phy_pkg::*;
#(
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int LANE_W    = LANE_W_DEF,
    parameter int RX_DEPTH  = RX_DEPTH_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_send,
    input  logic              enable_receive,
    input  logic [FLIT_W-1:0] input_data_from_router,
    input  logic              input_valid,
    output logic              input_ready,
    output logic [FLIT_W-1:0] output_data_to_router,
    output logic              output_valid,
    input  logic              output_ready,
    output logic [LANE_W-1:0] serial_data_out,
    output logic              write_req_send,
    input  logic              write_ready_ack,
    input  logic [LANE_W-1:0] serial_data_in,
    input  logic              read_req_received,
    output logic              read_ready,
    output logic              rx_frame_err
);

    localparam int BEATS  = FLIT_W / LANE_W;
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam int CNT_W  = $clog2(RX_DEPTH + 1);

    if (FLIT_W % LANE_W != 0) begin : g_bad_width
        $error("FLIT_W must be a multiple of LANE_W");
    end
    if (!is_pow2(RX_DEPTH) || RX_DEPTH < 2) begin : g_bad_depth
        $error("RX_DEPTH must be a power of two and at least 2");
    end

    // ---------------- TX side ----------------
    tx_state_e         state_q, state_d;
    logic              tx_full_q, tx_full_d;
    logic [BEAT_W-1:0] tx_beat_q, tx_beat_d;
    logic [FLIT_W-1:0] tx_data_q, tx_data_d;
    logic              tx_last;

    assign input_ready = ~tx_full_q;
    assign tx_last     = (tx_beat_q == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            tx_full_q <= 1'b0;
            tx_beat_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_full_q <= tx_full_d;
            tx_beat_q <= tx_beat_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_data_q <= tx_data_d;
    end

    // The holding register doubles as the shift register: the outgoing beat
    // is always taken from one end and the flit shifts toward it each beat.
    always_comb begin
        state_d   = state_q;
        tx_full_d = tx_full_q;
        tx_beat_d = tx_beat_q;
        tx_data_d = tx_data_q;
        if (input_valid && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_data_d = input_data_from_router;
        end
        case (state_q)
            TX_IDLE: begin
                if (tx_full_q && enable_send && write_ready_ack) begin
                    state_d   = TX_SEND;
                    tx_beat_d = '0;
                end
            end
            TX_SEND: begin
                tx_data_d = MSB_FIRST ? (tx_data_q << LANE_W) : (tx_data_q >> LANE_W);
                if (tx_last) begin
                    state_d   = TX_IDLE;
                    tx_full_d = 1'b0;
                    tx_beat_d = '0;
                end else begin
                    tx_beat_d = tx_beat_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        write_req_send  = 1'b0;
        serial_data_out = '0;
        if (state_q == TX_SEND) begin
            write_req_send  = 1'b1;
            serial_data_out = MSB_FIRST ? tx_data_q[FLIT_W-1 -: LANE_W]
                                        : tx_data_q[LANE_W-1:0];
        end
    end

    // ---------------- RX side ----------------
    logic [BEAT_W-1:0] rx_beat_q, rx_beat_d;
    logic [FLIT_W-1:0] rx_asm_q, rx_asm_d, rx_asm_next;
    logic              err_q, err_d;
    logic              rx_busy, frame_done;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [FLIT_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  rx_count;

    assign rx_busy    = (rx_beat_q != '0);
    assign frame_done = read_req_received && (rx_beat_q == BEAT_W'(BEATS - 1));
    assign fifo_pop   = output_ready & ~fifo_empty;

    // Beat 0 must end up at the end of the flit it was taken from on the TX side.
    assign rx_asm_next = MSB_FIRST
        ? ((rx_asm_q << LANE_W) | FLIT_W'(serial_data_in))
        : ((rx_asm_q >> LANE_W) | (FLIT_W'(serial_data_in) << (FLIT_W - LANE_W)));

    always_comb begin
        rx_beat_d = rx_beat_q;
        rx_asm_d  = rx_asm_q;
        err_d     = 1'b0;
        if (read_req_received) begin
            rx_asm_d  = rx_asm_next;
            rx_beat_d = frame_done ? '0 : rx_beat_q + 1'b1;
            // A full FIFO with no pop this cycle drops the completed flit.
            if (frame_done && fifo_full && !fifo_pop) err_d = 1'b1;
        end else if (rx_busy) begin
            rx_beat_d = '0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_beat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rx_beat_q <= rx_beat_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_asm_q <= rx_asm_d;
    end

    phy_rx_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (frame_done),
        .wdata_i (rx_asm_next),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (rx_count)
    );

    // rst is folded in so read_ready stays low for the whole reset window.
    assign read_ready            = ~rst & enable_receive & ~rx_busy & (rx_count < CNT_W'(RX_DEPTH));
    assign output_valid          = ~fifo_empty;
    assign output_data_to_router = fifo_empty ? '0 : fifo_rdata;
    assign rx_frame_err          = err_q;

endmodule
